// File: rtl/ropuf_pkg.sv
// Shared definitions for the ring-oscillator PUF challenge sequencer.
//   - state_e : sequencer state encoding
//   - NCHAL   : number of challenges per response
//   - SEL_W   : width of the challenge select
//   - COUNT_W : width of the pair counters feeding the compare path
package ropuf_pkg;

  localparam int unsigned NCHAL   = 4;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned COUNT_W = 4;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StRun,
    StSettle,
    StSample,
    StDone
  } state_e;

endpackage

// File: rtl/ropuf_window_timer.sv
// Loadable down-counter used to time the RUN and SETTLE intervals.
// Ports:
//   i_clk      : clock, rising edge
//   i_rst      : asynchronous active-high reset
//   i_load     : load i_load_val (takes priority over decrement)
//   i_load_val : value to load
//   i_dec      : decrement; saturates at zero
//   o_zero     : count is zero
module ropuf_window_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/ropuf_challenge_ctrl.sv
// Sequencer for the 4-challenge ring-oscillator PUF datapath. Each START runs
// CLEAR / RUN / SETTLE / SAMPLE once per challenge and publishes the response.
// Optional feature macro: ROPUF_TIE_FLAG_EN adds the TIE output (equal-count flags).
// Ports:
//   CLK, RESET       : clock and asynchronous active-high reset
//   START, ABORT     : run request (IDLE only) and run cancel (busy states only)
//   COUNT1, COUNT2   : pair counter values
//   RO_EN, RO_RESET  : oscillator/counter enable and counter clear
//   SEL              : challenge select to both muxes
//   BUSY, DONE       : run in progress / one-cycle completion pulse
//   RESP             : response, RESP[i] from challenge i
//   TIE              : (ROPUF_TIE_FLAG_EN only) TIE[i] set when counts were equal
module ropuf_challenge_ctrl
  import ropuf_pkg::*;
#(
  parameter int unsigned WINDOW = 8,
  parameter int unsigned SETTLE = 2
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               START,
  input  logic               ABORT,
  input  logic [COUNT_W-1:0] COUNT1,
  input  logic [COUNT_W-1:0] COUNT2,
  output logic               RO_EN,
  output logic               RO_RESET,
  output logic [SEL_W-1:0]   SEL,
  output logic               BUSY,
  output logic               DONE,
`ifdef ROPUF_TIE_FLAG_EN
  output logic [NCHAL-1:0]   TIE,
`endif
  output logic [NCHAL-1:0]   RESP
);

  // One timer serves both intervals, so it must hold the larger of the two.
  localparam int unsigned TMR_MAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  // Loaded with N-1: the interval ends in the cycle the count reads zero.
  localparam logic [TMR_W-1:0] WIN_LD = TMR_W'(WINDOW - 1);
  localparam logic [TMR_W-1:0] SET_LD = TMR_W'((SETTLE > 0) ? (SETTLE - 1) : 0);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NCHAL - 1);

  state_e           r_state;
  state_e           w_state_d;
  logic [SEL_W-1:0] r_idx;
  logic [NCHAL-1:0] r_shadow;
  logic [NCHAL-1:0] r_resp;
  logic [NCHAL-1:0] w_shadow_upd;
  logic             w_busy;
  logic             w_tmr_load;
  logic [TMR_W-1:0] w_tmr_load_val;
  logic             w_tmr_dec;
  logic             w_tmr_zero;
  logic             w_sample;

  assign w_busy = (r_state == StClear) || (r_state == StRun) ||
                  (r_state == StSettle) || (r_state == StSample);

  // SAMPLE is cancelled by ABORT like any other busy-state transition.
  assign w_sample = (r_state == StSample) && !ABORT;

  // ---------------------------------------------------------------- timer
  always_comb begin
    w_tmr_load     = 1'b0;
    w_tmr_load_val = WIN_LD;
    w_tmr_dec      = 1'b0;
    if (r_state == StClear) begin
      w_tmr_load     = 1'b1;
      w_tmr_load_val = WIN_LD;
    end else if (r_state == StRun) begin
      w_tmr_dec = 1'b1;
      if (w_tmr_zero) begin
        w_tmr_load     = 1'b1;
        w_tmr_load_val = SET_LD;
      end
    end else if (r_state == StSettle) begin
      w_tmr_dec = 1'b1;
    end
  end

  ropuf_window_timer #(
    .WIDTH (TMR_W)
  ) u_timer (
    .i_clk      (CLK),
    .i_rst      (RESET),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_load_val),
    .i_dec      (w_tmr_dec),
    .o_zero     (w_tmr_zero)
  );

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:   if (START) w_state_d = StClear;
      StClear:  w_state_d = StRun;
      StRun:    if (w_tmr_zero) w_state_d = (SETTLE == 0) ? StSample : StSettle;
      StSettle: if (w_tmr_zero) w_state_d = StSample;
      StSample: w_state_d = (r_idx == LAST_IDX) ? StDone : StClear;
      StDone:   w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
    if (ABORT && w_busy) begin
      w_state_d = StIdle;
    end
  end

  always_comb begin
    RO_EN    = 1'b0;
    RO_RESET = 1'b0;
    SEL      = '0;
    BUSY     = w_busy;
    DONE     = 1'b0;
    unique case (r_state)
      StIdle:   ;
      StClear: begin
        RO_RESET = 1'b1;
        SEL      = r_idx;
      end
      StRun: begin
        RO_EN = 1'b1;
        SEL   = r_idx;
      end
      StSettle: SEL = r_idx;
      StSample: SEL = r_idx;
      StDone:   DONE = 1'b1;
      default:  ;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_comb begin
    w_shadow_upd        = r_shadow;
    w_shadow_upd[r_idx] = (COUNT1 > COUNT2);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_idx    <= '0;
      r_shadow <= '0;
      r_resp   <= '0;
    end else begin
      if (r_state == StIdle) begin
        r_idx <= '0;
      end else if (w_sample) begin
        r_shadow <= w_shadow_upd;
        if (r_idx == LAST_IDX) begin
          r_resp <= w_shadow_upd;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end
    end
  end

  assign RESP = r_resp;

`ifdef ROPUF_TIE_FLAG_EN
  logic [NCHAL-1:0] r_tie_shadow;
  logic [NCHAL-1:0] r_tie;
  logic [NCHAL-1:0] w_tie_upd;

  always_comb begin
    w_tie_upd        = r_tie_shadow;
    w_tie_upd[r_idx] = (COUNT1 == COUNT2);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_tie_shadow <= '0;
      r_tie        <= '0;
    end else if (w_sample) begin
      r_tie_shadow <= w_tie_upd;
      if (r_idx == LAST_IDX) begin
        r_tie <= w_tie_upd;
      end
    end
  end

  assign TIE = r_tie;
`endif

endmodule

// File: tb/tb_ropuf_challenge_ctrl.sv
// Directed bench for ropuf_challenge_ctrl: instance A (WINDOW=8, SETTLE=2) and
// instance B (WINDOW=1, SETTLE=0). Inputs are routed to one instance at a time.
module tb_ropuf_challenge_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic       use_b;
  logic [3:0] c1;
  logic [3:0] c2;

  logic       a_ro_en, a_ro_reset, a_busy, a_done;
  logic [1:0] a_sel;
  logic [3:0] a_resp;
  logic       b_ro_en, b_ro_reset, b_busy, b_done;
  logic [1:0] b_sel;
  logic [3:0] b_resp;
`ifdef ROPUF_TIE_FLAG_EN
  logic [3:0] a_tie;
  logic [3:0] b_tie;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ropuf_challenge_ctrl #(
    .WINDOW (8),
    .SETTLE (2)
  ) u_dut_a (
    .CLK      (clk),
    .RESET    (rst),
    .START    (start & ~use_b),
    .ABORT    (abort & ~use_b),
    .COUNT1   (c1),
    .COUNT2   (c2),
    .RO_EN    (a_ro_en),
    .RO_RESET (a_ro_reset),
    .SEL      (a_sel),
    .BUSY     (a_busy),
    .DONE     (a_done),
`ifdef ROPUF_TIE_FLAG_EN
    .TIE      (a_tie),
`endif
    .RESP     (a_resp)
  );

  ropuf_challenge_ctrl #(
    .WINDOW (1),
    .SETTLE (0)
  ) u_dut_b (
    .CLK      (clk),
    .RESET    (rst),
    .START    (start & use_b),
    .ABORT    (abort & use_b),
    .COUNT1   (c1),
    .COUNT2   (c2),
    .RO_EN    (b_ro_en),
    .RO_RESET (b_ro_reset),
    .SEL      (b_sel),
    .BUSY     (b_busy),
    .DONE     (b_done),
`ifdef ROPUF_TIE_FLAG_EN
    .TIE      (b_tie),
`endif
    .RESP     (b_resp)
  );

  // Observed outputs of the selected instance, widened to 4 bits for chk().
  logic [3:0] o_en, o_rst, o_sel, o_busy, o_done, o_resp;
  assign o_en   = {3'b000, use_b ? b_ro_en    : a_ro_en};
  assign o_rst  = {3'b000, use_b ? b_ro_reset : a_ro_reset};
  assign o_sel  = {2'b00,  use_b ? b_sel      : a_sel};
  assign o_busy = {3'b000, use_b ? b_busy     : a_busy};
  assign o_done = {3'b000, use_b ? b_done     : a_done};
  assign o_resp = use_b ? b_resp : a_resp;
`ifdef ROPUF_TIE_FLAG_EN
  logic [3:0] o_tie;
  assign o_tie = use_b ? b_tie : a_tie;
`endif

  function automatic logic [3:0] b4(input logic b);
    return {3'b000, b};
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Idle-state output check (after DONE, after abort, after reset).
  task automatic chk_idle(input string tag, input logic [3:0] exp_resp);
    chk({tag, "_en"},   o_en,   4'd0);
    chk({tag, "_rst"},  o_rst,  4'd0);
    chk({tag, "_sel"},  o_sel,  4'd0);
    chk({tag, "_busy"}, o_busy, 4'd0);
    chk({tag, "_done"}, o_done, 4'd0);
    chk({tag, "_resp"}, o_resp, exp_resp);
  endtask

  // One START-initiated run; cycle k=1 is the CLEAR of challenge 0.
  // abort_at / extra_at: cycle in which ABORT / a stray START is driven (0 = none).
  // Returns positioned in the first IDLE cycle after DONE (or after abort checks).
  task automatic run(input int w, input int s, input int abort_at, input int extra_at,
                     input logic [3:0] exp_resp, input logic [3:0] exp_tie,
                     input logic [3:0] prev_resp, input logic [3:0] prev_tie);
    int   p, t, ch, ph;
    bit   aborted, done_seen;
    int   c1_on [4] = '{9, 2, 5, 15};
    int   c2_on [4] = '{3, 7, 5, 0};
    // Off-cycle counts give the opposite (non-tie) result, exposing a mistimed sample.
    int   c1_off[4] = '{1, 8, 8, 1};
    int   c2_off[4] = '{8, 1, 1, 8};
    p       = w + s + 2;
    t       = 1 + 4 * p;
    aborted = 1'b0;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    for (int k = 1; k <= t + 1; k++) begin
      ch = (k - 1) / p;
      ph = (k - 1) % p;
      if (k < t) begin
        chk("ro_reset", o_rst,  b4(ph == 0));
        chk("ro_en",    o_en,   b4(ph >= 1 && ph <= w));
        chk("sel",      o_sel,  4'(ch));
        chk("busy",     o_busy, 4'd1);
        chk("done",     o_done, 4'd0);
        chk("resp_hold", o_resp, prev_resp);
`ifdef ROPUF_TIE_FLAG_EN
        chk("tie_hold", o_tie, prev_tie);
`endif
        c1 = (ph == p - 1) ? 4'(c1_on[ch]) : 4'(c1_off[ch]);
        c2 = (ph == p - 1) ? 4'(c2_on[ch]) : 4'(c2_off[ch]);
      end else if (k == t) begin
        chk("done_pulse", o_done, 4'd1);
        chk("done_busy",  o_busy, 4'd0);
        chk("done_sel",   o_sel,  4'd0);
        chk("done_en",    o_en,   4'd0);
        chk("resp",       o_resp, exp_resp);
`ifdef ROPUF_TIE_FLAG_EN
        chk("tie", o_tie, exp_tie);
`endif
      end else begin
        chk_idle("post", exp_resp);
`ifdef ROPUF_TIE_FLAG_EN
        chk("post_tie", o_tie, exp_tie);
`endif
      end
      start = (k == extra_at);
      abort = (k == abort_at);
      if (k <= t) tick();
      if (k == abort_at) begin
        aborted = 1'b1;
        break;
      end
    end
    start = 1'b0;
    abort = 1'b0;
    if (aborted) begin
      chk_idle("abort", prev_resp);
`ifdef ROPUF_TIE_FLAG_EN
      chk("abort_tie", o_tie, prev_tie);
`endif
      done_seen = 1'b0;
      for (int k = 0; k < t; k++) begin
        tick();
        if (o_done[0] || o_busy[0]) done_seen = 1'b1;
      end
      chk("abort_quiet", b4(done_seen), 4'd0);
      chk("abort_resp",  o_resp, prev_resp);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    use_b = 1'b0;
    c1    = 4'd0;
    c2    = 4'd0;
    tick();
    tick();
    // Reset values, both instances.
    chk_idle("rst_a", 4'd0);
`ifdef ROPUF_TIE_FLAG_EN
    chk("rst_a_tie", o_tie, 4'd0);
`endif
    use_b = 1'b1;
    #1;
    chk_idle("rst_b", 4'd0);
    use_b = 1'b0;
    rst   = 1'b0;
    tick();
    chk_idle("idle_a", 4'd0);

    // Nominal run: RESP 1001, TIE 0100.
    run(8, 2, 0, 0, 4'b1001, 4'b0100, 4'b0000, 4'b0000);

    // Stray START in challenge 1 SETTLE (cycle 23) must be ignored.
    run(8, 2, 0, 23, 4'b1001, 4'b0100, 4'b1001, 4'b0100);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("one_run_busy", o_busy, 4'd0);
    end

    // ABORT during challenge 2 RUN (cycle 28): IDLE next cycle, RESP retained.
    run(8, 2, 28, 0, 4'b1001, 4'b0100, 4'b1001, 4'b0100);

    // Asynchronous reset in challenge 1 RUN (cycle 15).
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (14) tick();
    chk("pre_rst_en",  o_en,  4'd1);
    chk("pre_rst_sel", o_sel, 4'd1);
    #2 rst = 1'b1;
    #1;
    chk_idle("async_rst", 4'd0);
`ifdef ROPUF_TIE_FLAG_EN
    chk("async_rst_tie", o_tie, 4'd0);
`endif
    tick();
    rst = 1'b0;
    tick();
    chk_idle("rst_release", 4'd0);
    run(8, 2, 0, 0, 4'b1001, 4'b0100, 4'b0000, 4'b0000);

    // WINDOW=1, SETTLE=0: DONE at 13, back-to-back START at 14, second DONE at 27.
    use_b = 1'b1;
    tick();
    run(1, 0, 0, 0, 4'b1001, 4'b0100, 4'b0000, 4'b0000);
    run(1, 0, 0, 0, 4'b1001, 4'b0100, 4'b1001, 4'b0100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
